regfile_wb_arbiter: RTL



---
 rtl/regfile_wb_arbiter_pkg.sv | 37 +++
 rtl/regfile_wb_arbiter_if.sv | 75 +++++++
 rtl/regfile_wb_arbiter_rr_pick.sv | 45 ++++
 rtl/regfile_wb_arbiter.sv | 117 +++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter_pkg
//   Shared definitions for the register-file writeback arbiter slice.
//   - Default sizing for the number of writeback sources and the
//     register index / data widths.
//   - Symbolic requester indices for the three standard sources.
//   - The hardwired-zero register index.
//   - A one-hot helper used by both the picker and anyone decoding grants.
// ----------------------------------------------------------------------------
package regfile_wb_arbiter_pkg;

    localparam int DEF_NUM_REQ = 3;
    localparam int DEF_ADDR_W  = 5;
    localparam int DEF_DATA_W  = 32;

    // Width of grant_id on the output stage; large enough for 8 requesters.
    localparam int GRANT_ID_W = 3;

    // Requester slot assignment on the shared write port.
    typedef enum logic [GRANT_ID_W-1:0] {
        REQ_ALU = 3'd0,
        REQ_MEM = 3'd1,
        REQ_SYS = 3'd2
    } req_id_e;

    // Writes to this index are accepted but never reach the register file.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // One-hot of an index into an 8-bit vector; callers truncate to width.
    function automatic logic [7:0] onehot8(input logic [GRANT_ID_W-1:0] idx);
        logic [7:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage : regfile_wb_arbiter_pkg

// File: rtl/regfile_wb_arbiter_if.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter_if
//   Bundles the writeback request side and the register-file write side of
//   the arbiter.
//
//   Handshake: requester i offers a write by raising req_valid[i] with
//   req_reg/req_data slice i stable; the write is taken at the first posedge
//   where req_valid[i] and req_ready[i] are both high. A requester must not
//   drop valid or change its payload before that edge. req_ready is
//   combinational, one-hot or zero.
//
//   Signals
//     req_valid  [NUM_REQ]          per-requester write request
//     req_reg    [NUM_REQ*ADDR_W]   packed destinations, slice i*ADDR_W
//     req_data   [NUM_REQ*DATA_W]   packed data, slice i*DATA_W
//     req_ready  [NUM_REQ]          one-hot grant
//     write_reg  [ADDR_W]           register file write index
//     write_data [DATA_W]           register file write data
//     reg_write                     register file write enable
//     grant_id   [3]                requester whose write sits in the output stage
//     zero_drop                     pulse: accepted write to register 0 discarded
//     dbg_rr_ptr [3]                current round-robin start position
//
//   Modports
//     slave  - the arbiter
//     master - the requesters / register-file side environment
// ----------------------------------------------------------------------------
interface regfile_wb_arbiter_if
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_reg;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;

    logic [ADDR_W-1:0]         write_reg;
    logic [DATA_W-1:0]         write_data;
    logic                      reg_write;
    logic [GRANT_ID_W-1:0]     grant_id;
    logic                      zero_drop;

    logic [GRANT_ID_W-1:0]     dbg_rr_ptr;

    modport slave (
        input  req_valid,
        input  req_reg,
        input  req_data,
        output req_ready,
        output write_reg,
        output write_data,
        output reg_write,
        output grant_id,
        output zero_drop,
        output dbg_rr_ptr
    );

    modport master (
        output req_valid,
        output req_reg,
        output req_data,
        input  req_ready,
        input  write_reg,
        input  write_data,
        input  reg_write,
        input  grant_id,
        input  zero_drop,
        input  dbg_rr_ptr
    );

endinterface : regfile_wb_arbiter_if

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// regfile_rr_pick
//   Purely combinational round-robin priority picker. Scans the valid vector
//   cyclically starting at rr_ptr and grants the first set bit.
//
//   Ports
//     valid     in  [NUM_REQ]  request vector
//     rr_ptr    in  [PTR_W]    highest-priority position this cycle
//     grant     out [NUM_REQ]  one-hot grant, zero when nothing is valid
//     grant_idx out [PTR_W]    encoded index of the granted bit (0 if none)
//     grant_any out            at least one request is valid
// ----------------------------------------------------------------------------
module regfile_rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               grant_any
);

    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Position k steps after the pointer, wrapped without a modulo
            // operator since both terms are below NUM_REQ.
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_any && valid[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = PTR_W'(idx);
                grant_any  = 1'b1;
            end
        end
    end

endmodule : regfile_rr_pick

// File: rtl/regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter
//   Shares the single register-file write port among NUM_REQ writeback
//   sources (ALU, load return, syscall/HI-LO). One source is granted per
//   cycle in round-robin order; the winning write is registered and driven
//   to the register file, which commits it on the following posedge.
//   Writes targeting register 0 are accepted, then dropped with a zero_drop
//   pulse instead of reg_write.
//
//   Ports
//     clk  in   system clock, all state on posedge
//     rst  in   synchronous active-high reset
//     bus  slave modport of regfile_wb_arbiter_if (request + write sides)
//
//   The interface instance must be parameterised identically to this module.
// ----------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_wb_arbiter_if.slave   bus
);

    localparam int PTR_W = $clog2(NUM_REQ);

    // Round-robin start position; always in 0..NUM_REQ-1.
    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      next_ptr;

    logic [NUM_REQ-1:0]    pick_grant;
    logic [PTR_W-1:0]      pick_idx;
    logic                  pick_any;
    logic                  transfer;

    logic [ADDR_W-1:0]     sel_reg;
    logic [DATA_W-1:0]     sel_data;

    // Output stage registers.
    logic [ADDR_W-1:0]     out_reg_q;
    logic [DATA_W-1:0]     out_data_q;
    logic                  out_we_q;
    logic [GRANT_ID_W-1:0] out_id_q;
    logic                  out_zero_q;

    regfile_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .valid     (bus.req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .grant_any (pick_any)
    );

    // Ready is suppressed during reset so nothing is accepted in that cycle.
    // The picker only grants valid requesters, so any grant is a transfer.
    assign bus.req_ready = rst ? '0 : pick_grant;
    assign transfer      = pick_any && !rst;

    // Payload mux for the granted requester.
    always_comb begin
        sel_reg  = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i == int'(pick_idx)) begin
                sel_reg  = bus.req_reg[i*ADDR_W +: ADDR_W];
                sel_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Pointer moves to the slot after the winner, wrapping at NUM_REQ-1.
    always_comb begin
        if (int'(pick_idx) == NUM_REQ - 1) begin
            next_ptr = '0;
        end else begin
            next_ptr = pick_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            out_reg_q  <= '0;
            out_data_q <= '0;
            out_we_q   <= 1'b0;
            out_id_q   <= '0;
            out_zero_q <= 1'b0;
        end else begin
            // Enables are single-cycle; index/data/id hold when idle.
            out_we_q   <= 1'b0;
            out_zero_q <= 1'b0;
            if (transfer) begin
                rr_ptr     <= next_ptr;
                out_reg_q  <= sel_reg;
                out_data_q <= sel_data;
                out_id_q   <= GRANT_ID_W'(pick_idx);
                out_we_q   <= (sel_reg != ADDR_W'(REG_ZERO));
                out_zero_q <= (sel_reg == ADDR_W'(REG_ZERO));
            end
        end
    end

    assign bus.write_reg  = out_reg_q;
    assign bus.write_data = out_data_q;
    assign bus.reg_write  = out_we_q;
    assign bus.grant_id   = out_id_q;
    assign bus.zero_drop  = out_zero_q;
    assign bus.dbg_rr_ptr = GRANT_ID_W'(rr_ptr);

endmodule : regfile_wb_arbiter
